// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the external 16-bit asynchronous SRAM controller.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
   localparam logic        HALF_LO       = 1'b0;
   localparam logic        HALF_HI       = 1'b1;
   localparam int unsigned CNT_W         = 4;

   // Request captured in IDLE and held for the whole access.
   typedef struct packed {
      logic        wr;
      logic [31:0] data;
   } req_t;

endpackage

// File: rtl/sram_ctrl.sv
// Multi-cycle data-memory controller: splits each 32-bit load/store into two
// halfword phases on an asynchronous SRAM and freezes the pipeline meanwhile.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF,
   parameter int unsigned SRAM_AW       = 18,
   parameter int unsigned ACCESS_CYCLES = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   localparam int unsigned      WORD_W = SRAM_AW - 1;
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(ACCESS_CYCLES - 1);

   generate
      if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15) begin : g_bad_cycles
         $error("sram_ctrl: ACCESS_CYCLES must lie in 2..15");
      end
   endgenerate

   state_t              state, state_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   req_t                req, req_nx;
   logic [WORD_W-1:0]   word, word_nx, word_in;
   logic [15:0]         rbuf, rbuf_nx;
   logic [31:0]         read_data_nx;
   logic [SRAM_AW-1:0]  sram_addr_nx;
   logic [15:0]         dq_out_nx;
   logic                oe_nx, we_n_nx, half, last;

   // Out-of-range addresses simply alias: only off[SRAM_AW:2] survives.
   assign word_in = WORD_W'((address - BASE_ADDR) >> 2);
   assign last    = (cnt == LAST);

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      req_nx       = req;
      word_nx      = word;
      rbuf_nx      = rbuf;
      read_data_nx = read_data;
      ready        = 1'b0;
      sram_addr_nx = sram_addr;
      dq_out_nx    = sram_dq_out;
      oe_nx        = 1'b0;
      we_n_nx      = 1'b1;
      half         = HALF_LO;

      case (state)
         IDLE: begin
            ready = ~(rd_en | wr_en);
            if (rd_en | wr_en) begin
               state_nx    = LO;
               cnt_nx      = '0;
               req_nx.wr   = wr_en;
               req_nx.data = write_data;
               word_nx     = word_in;
            end
         end
         LO: begin
            if (last) begin
               state_nx = HI;
               cnt_nx   = '0;
               if (!req.wr) rbuf_nx = sram_dq_in;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         HI: begin
            if (last) begin
               state_nx = DONE;
               cnt_nx   = '0;
               if (!req.wr) read_data_nx = {sram_dq_in, rbuf};
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         DONE: begin
            ready    = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // Pad outputs are registered, so derive them from the upcoming phase.
      if (state_nx == LO || state_nx == HI) begin
         half         = (state_nx == HI) ? HALF_HI : HALF_LO;
         sram_addr_nx = {word_nx, half};
         if (req_nx.wr) begin
            oe_nx     = 1'b1;
            dq_out_nx = (half == HALF_HI) ? req_nx.data[31:16] : req_nx.data[15:0];
            we_n_nx   = (cnt_nx == LAST);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         req         <= '0;
         word        <= '0;
         rbuf        <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         req         <= req_nx;
         word        <= word_nx;
         rbuf        <= rbuf_nx;
         read_data   <= read_data_nx;
         sram_addr   <= sram_addr_nx;
         sram_dq_out <= dq_out_nx;
         sram_dq_oe  <= oe_nx;
         sram_we_n   <= we_n_nx;
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural 16-bit async SRAM and
// a queue of expected load values.
module tb_sram_ctrl;

   localparam int unsigned A   = 3;
   localparam int unsigned AW  = 18;
   localparam int          LAT = 2 * A + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_en, wr_en;
   logic [31:0]   address, write_data, read_data;
   logic          ready;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out, sram_dq_in;
   logic          sram_dq_oe, sram_we_n;

   sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(AW), .ACCESS_CYCLES(A)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
   );

   // SRAM model: asynchronous read, write on the rising edge of we_n.
   logic [15:0] mem [0:(1<<AW)-1];
   assign sram_dq_in = mem[sram_addr];
   always @(posedge sram_we_n) mem[sram_addr] <= sram_dq_out;

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;
   logic        tr_ready [0:47];
   logic        tr_we    [0:47];
   logic        tr_oe    [0:47];
   logic [17:0] tr_addr  [0:47];
   logic [15:0] tr_dq    [0:47];
   logic [31:0] done_data;
   int          lat;

   // Issue one request and hold it until ready; records a per-cycle trace.
   // Address/data are scrambled mid-access to show they are not re-sampled.
   task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d);
      @(posedge clk); #1;
      rd_en = rd; wr_en = wr; address = a; write_data = d;
      lat = -1;
      for (int c = 0; c < 48; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         else #1;
         tr_ready[c] = ready; tr_we[c] = sram_we_n; tr_oe[c] = sram_dq_oe;
         tr_addr[c]  = sram_addr; tr_dq[c] = sram_dq_out;
         if (ready) begin lat = c; done_data = read_data; break; end
         if (c == 2) begin address = $urandom; write_data = $urandom; end
      end
   endtask

   task automatic idle_cycles(input int n);
      rd_en = 1'b0; wr_en = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk); #3 rst = 1'b1;
      repeat (2) @(posedge clk); #3 rst = 1'b0; #1;
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
      vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
      vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe: got %b want 0", sram_dq_oe); end
      vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", read_data); end
      vectors++; if (sram_addr !== 18'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
      #1 rst = 1'b1;
   endtask

   task automatic test_store_load;
      run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF); idle_cycles(1);
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL store_lat: got %0d want %0d", lat, LAT); end
      vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL store_keeps_rdata: got %h want 0", read_data); end
      vectors++; if (mem[2] !== 16'hBEEF) begin miscompares++; $display("FAIL store_mem_lo: got %h want beef", mem[2]); end
      vectors++; if (mem[3] !== 16'hDEAD) begin miscompares++; $display("FAIL store_mem_hi: got %h want dead", mem[3]); end
      exp_q.push_back(32'hDEADBEEF);
      run_access(1'b1, 1'b0, 32'd1028, 32'h0); idle_cycles(1);
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL load_lat: got %0d want %0d", lat, LAT); end
      exp_v = exp_q.pop_front();
      vectors++; if (done_data !== exp_v) begin miscompares++; $display("FAIL load_data: got %h want %h", done_data, exp_v); end
   endtask

   task automatic test_we_timing;
      int lows;
      lows = 0;
      run_access(1'b0, 1'b1, 32'd1100, 32'hCAFEF00D); idle_cycles(1);
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL wt_lat: got %0d want %0d", lat, LAT); end
      vectors++; if (tr_ready[0] !== 1'b0) begin miscompares++; $display("FAIL wt_freeze0: got %b want 0", tr_ready[0]); end
      for (int c = 1; c <= 2 * A; c++) begin
         logic        ew;
         logic [17:0] ea;
         logic [15:0] ed;
         ew = ((c - 1) % A) == (A - 1);
         ea = (c <= A) ? 18'd38 : 18'd39;
         ed = (c <= A) ? 16'hF00D : 16'hCAFE;
         if (tr_we[c] === 1'b0) lows++;
         vectors++; if (tr_we[c] !== ew) begin miscompares++; $display("FAIL wt_we_c%0d: got %b want %b", c, tr_we[c], ew); end
         vectors++; if (tr_oe[c] !== 1'b1) begin miscompares++; $display("FAIL wt_oe_c%0d: got %b want 1", c, tr_oe[c]); end
         vectors++; if (tr_addr[c] !== ea) begin miscompares++; $display("FAIL wt_addr_c%0d: got %h want %h", c, tr_addr[c], ea); end
         vectors++; if (tr_dq[c] !== ed) begin miscompares++; $display("FAIL wt_dq_c%0d: got %h want %h", c, tr_dq[c], ed); end
      end
      vectors++; if (lows !== 2 * (A - 1)) begin miscompares++; $display("FAIL wt_low_count: got %0d want %0d", lows, 2 * (A - 1)); end
      vectors++; if (tr_we[LAT] !== 1'b1 || tr_oe[LAT] !== 1'b0) begin miscompares++; $display("FAIL wt_done_pads: got we_n=%b oe=%b want 1/0", tr_we[LAT], tr_oe[LAT]); end
   endtask

   task automatic test_back_to_back;
      int          lat1;
      logic [31:0] d1;
      run_access(1'b0, 1'b1, 32'd1024, 32'h0BADF00D);
      run_access(1'b0, 1'b1, 32'd1032, 32'h7E57C0DE); idle_cycles(1);
      exp_q.push_back(32'h0BADF00D); exp_q.push_back(32'h7E57C0DE);
      run_access(1'b1, 1'b0, 32'd1024, 32'h0); lat1 = lat; d1 = done_data;
      run_access(1'b1, 1'b0, 32'd1032, 32'h0);
      rd_en = 1'b0;
      vectors++; if (lat1 !== LAT) begin miscompares++; $display("FAIL b2b_lat1: got %0d want %0d", lat1, LAT); end
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL b2b_lat2: got %0d want %0d", lat, LAT); end
      vectors++; if (tr_ready[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_start: got %b want 0", tr_ready[0]); end
      vectors++; if (tr_addr[1] !== 18'd4) begin miscompares++; $display("FAIL b2b_addr: got %h want 4", tr_addr[1]); end
      exp_v = exp_q.pop_front();
      vectors++; if (d1 !== exp_v) begin miscompares++; $display("FAIL b2b_data1: got %h want %h", d1, exp_v); end
      exp_v = exp_q.pop_front();
      vectors++; if (done_data !== exp_v) begin miscompares++; $display("FAIL b2b_data2: got %h want %h", done_data, exp_v); end
      @(posedge clk); #1;
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL b2b_no_dup: got %b want 1", ready); end
   endtask

   task automatic test_boundary;
      run_access(1'b1, 1'b1, 32'd1020, 32'h12345678); idle_cycles(1);
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL bnd_lat: got %0d want %0d", lat, LAT); end
      vectors++; if (tr_oe[1] !== 1'b1 || tr_we[1] !== 1'b0) begin miscompares++; $display("FAIL bnd_is_write: got oe=%b we_n=%b want 1/0", tr_oe[1], tr_we[1]); end
      vectors++; if (tr_addr[1] !== 18'h3FFFE) begin miscompares++; $display("FAIL bnd_addr_lo: got %h want 3fffe", tr_addr[1]); end
      vectors++; if (tr_addr[A + 1] !== 18'h3FFFF) begin miscompares++; $display("FAIL bnd_addr_hi: got %h want 3ffff", tr_addr[A + 1]); end
      vectors++; if (mem[18'h3FFFE] !== 16'h5678) begin miscompares++; $display("FAIL bnd_mem_lo: got %h want 5678", mem[18'h3FFFE]); end
      vectors++; if (mem[18'h3FFFF] !== 16'h1234) begin miscompares++; $display("FAIL bnd_mem_hi: got %h want 1234", mem[18'h3FFFF]); end
      vectors++; if (read_data !== 32'h7E57C0DE) begin miscompares++; $display("FAIL bnd_keeps_rdata: got %h want 7e57c0de", read_data); end
      exp_q.push_back(32'h12345678);
      run_access(1'b1, 1'b0, 32'd1020, 32'h0); idle_cycles(1);
      exp_v = exp_q.pop_front();
      vectors++; if (done_data !== exp_v) begin miscompares++; $display("FAIL bnd_load: got %h want %h", done_data, exp_v); end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'd1040; write_data = 32'hA5A55A5A;
      repeat (A + 1) @(posedge clk); #1;
      vectors++; if (sram_we_n !== 1'b0 || sram_addr !== 18'd9) begin miscompares++; $display("FAIL rm_in_hi: got we_n=%b addr=%h want 0/9", sram_we_n, sram_addr); end
      rst = 1'b0; wr_en = 1'b0; #1;
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready: got %b want 1", ready); end
      vectors++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL rm_pads: got we_n=%b oe=%b want 1/0", sram_we_n, sram_dq_oe); end
      vectors++; if (read_data !== 32'h0 || sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin miscompares++; $display("FAIL rm_regs: got rd=%h addr=%h dq=%h want 0", read_data, sram_addr, sram_dq_out); end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      vectors++; if (ready !== 1'b1 || sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL rm_after: got ready=%b oe=%b want 1/0", ready, sram_dq_oe); end
      exp_q.push_back(32'hDEADBEEF);
      run_access(1'b1, 1'b0, 32'd1028, 32'h0); idle_cycles(1);
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL rm_load_lat: got %0d want %0d", lat, LAT); end
      exp_v = exp_q.pop_front();
      vectors++; if (done_data !== exp_v) begin miscompares++; $display("FAIL rm_load_data: got %h want %h", done_data, exp_v); end
   endtask

   initial begin
      rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      test_reset;
      test_store_load;
      test_we_timing;
      test_back_to_back;
      test_boundary;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Multi-cycle controller placing the data memory in an external 16-bit asynchronous SRAM.
- Sits directly downstream of the memory stage: consumes the stage's load/store request (rd_en, wr_en, ALU-result address, store value) and returns the 32-bit load value.
- Holds ready low while an access is in flight; the top level uses ~ready to freeze every pipeline register and the PC.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM address width (16-bit halfword granularity).
- ACCESS_CYCLES, 3: cycles per halfword phase. Legal range is 2..15; an elaboration error fires outside it.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request from the memory stage.
- wr_en  in  1  store request from the memory stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store value.
- read_data  out  32  load result.
- ready  out  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- sram_addr  out  SRAM_AW  SRAM halfword address.
- sram_dq_out  out  16  write data to the SRAM pads.
- sram_dq_in  in  16  read data from the SRAM pads.
- sram_dq_oe  out  1  pad output enable; the top level builds the tristate from it.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low.
- Reset values:
  - state = IDLE, phase counter = 0.
  - read_data = 0, sram_addr = 0, sram_dq_out = 0.
  - sram_dq_oe = 0, sram_we_n = 1.
  - ready = 1 (combinational: IDLE with no request).
- Address arithmetic:
  - off = address - BASE_ADDR, modulo 2^32.
  - word = off[SRAM_AW:2]; upper bits are ignored, so out-of-range addresses alias without error.
  - sram_addr = {word, half}, with half = 0 for bits [15:0] and 1 for bits [31:16].
- States: IDLE, LO, HI, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational, so the freeze takes effect in the cycle the request appears.
  - On a request: latch address, write_data and op (write if wr_en, else read). Then go to LO with counter = 0.
  - rd_en & wr_en together is an illegal request; it is treated as a write.
- LO and HI: each lasts exactly ACCESS_CYCLES cycles; counter runs 0..ACCESS_CYCLES-1, then resets.
  - sram_addr is stable for the whole phase.
  - Write: sram_dq_oe = 1 for the whole phase. sram_dq_out = latched half. sram_we_n = 0 for counter < ACCESS_CYCLES-1 and 1 on the last cycle (data/address hold).
  - Read: sram_dq_oe = 0, sram_we_n = 1. sram_dq_in is sampled on the last cycle of the phase into the matching half of an internal buffer.
  - LO always goes to HI; HI always goes to DONE.
- DONE (one cycle):
  - ready = 1, sram_dq_oe = 0, sram_we_n = 1.
  - For a read, read_data updates with the full buffered word on entry to DONE and is valid during DONE.
  - read_data holds until the next read completes; writes never change it.
  - rd_en/wr_en are still asserted in DONE because the pipeline is frozen. They are ignored, and the pipeline advances on this edge.
  - DONE always goes to IDLE.
- Latency (request first seen in cycle 0):
  - LO occupies cycles 1..A, HI cycles A+1..2A, DONE cycle 2A+1, where A = ACCESS_CYCLES.
  - ready is low in cycles 0..2A and high in cycle 2A+1.
  - The earliest next request is at 2A+2.
  - Throughput is one access per 2A+2 cycles.
- Back-to-back requests: a request present in IDLE in the cycle right after DONE starts a new access immediately. No bubble beyond IDLE is required.
- Inputs are not re-sampled after IDLE; changes to address or write_data mid-access have no effect.
- Reset mid-access: the access is abandoned. Outputs return to reset values immediately, and the partial SRAM write is left as is.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum (IDLE, LO, HI, DONE), 2-bit encoding;
  - the BASE_ADDR default;
  - the halfword select constants HALF_LO = 0, HALF_HI = 1.
- No RTL sub-module.
- Bench-only model sram_model: a 2^SRAM_AW x 16 array with asynchronous read and a write on the sram_we_n rising edge.

Test Plan:
- Reset: assert rst=0 mid-idle -> ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Store then load, A=3: wr_en, address=1028, write_data=32'hDEADBEEF -> ready low for 7 cycles. Model then holds halfword addr 2 = 16'hBEEF and addr 3 = 16'hDEAD. A following rd_en at 1028 -> read_data=32'hDEADBEEF in DONE (cycle 7).
- we_n timing: during a store, sram_we_n is low exactly 2 cycles per phase and high on each phase's last cycle. sram_addr is constant per phase and sram_dq_oe=1 for all 6 phase cycles.
- Back-to-back: two loads issued on consecutive freeze releases (1024, 1032) -> second access starts the cycle after DONE. Exactly one ready pulse per access, no duplicate access in DONE.
- Boundary: address=1020 (below BASE_ADDR) -> aliases to word (2^32-4)[18:2] = 0x1FFFF, i.e. sram_addr 0x3FFFE/0x3FFFF. rd_en&wr_en=1 -> performs a write.
- Reset mid-access: drop rst=0 during HI of a store -> outputs at reset values within the same cycle. After release, ready=1 and the next load completes normally.
